// File: rtl/exhaustive_equiv_checker_pkg.sv
// Shared types and width helpers for the exhaustive equivalence checker.
// Holds the FSM state encoding and the mismatch-count width rule.
package equiv_chk_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      COMPARE = 2'd2,
      DONE    = 2'd3
   } chk_state_t;

   // Wide enough for the largest legal SETTLE_CYC (255).
   localparam int SETTLE_CNT_W = 8;

   // One extra bit so a sweep where every vector fails (2^in_w) cannot wrap.
   function automatic int mis_cnt_w(input int in_w);
      return in_w + 1;
   endfunction

endpackage

// File: rtl/exhaustive_equiv_checker_sweep.sv
// vector_sweep_counter: stimulus vector register, last-vector detect and
// per-vector settle counter for the exhaustive equivalence checker.
module vector_sweep_counter
   import equiv_chk_pkg::*;
#(
   parameter int IN_W       = 3,
   parameter int SETTLE_CYC = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  logic            settle_en,
   input  logic            step,
   output logic [IN_W-1:0] stim,
   output logic            last,
   output logic            settle_done
);

   logic [SETTLE_CNT_W-1:0] settle_cnt;

   // Stepping from the all-ones vector wraps stim back to zero, which is the
   // only way the vector returns to 0 outside of clear/reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stim       <= '0;
         settle_cnt <= '0;
      end else if (clear) begin
         stim       <= '0;
         settle_cnt <= '0;
      end else if (step) begin
         stim       <= stim + IN_W'(1);
         settle_cnt <= '0;
      end else if (settle_en) begin
         settle_cnt <= settle_cnt + SETTLE_CNT_W'(1);
      end
   end

   assign last        = &stim;
   assign settle_done = (settle_cnt == SETTLE_CNT_W'(SETTLE_CYC - 1));

endmodule

// File: rtl/exhaustive_equiv_checker.sv
// Exhaustive equivalence checker: sweeps every stimulus vector, compares a
// golden and a candidate design. Optional macro: FIRST_FAIL_CAPTURE_EN.
module exhaustive_equiv_checker
   import equiv_chk_pkg::*;
#(
   parameter int IN_W       = 3,
   parameter int OUT_W      = 1,
   parameter int SETTLE_CYC = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   output logic [IN_W-1:0]              stim_out,
   input  logic [OUT_W-1:0]             golden_in,
   input  logic [OUT_W-1:0]             cand_in,
   output logic                         busy,
   output logic                         done,
   output logic                         pass,
   output logic [mis_cnt_w(IN_W)-1:0]   mismatch_cnt,
   output logic [IN_W-1:0]              first_fail_vec,
   output logic                         first_fail_valid
);

   localparam int MC_W = mis_cnt_w(IN_W);

   chk_state_t state;
   logic       accept;
   logic       settle_en;
   logic       step;
   logic       last;
   logic       settle_done;
   logic       diff;

   assign accept    = start && ((state == IDLE) || (state == DONE));
   assign settle_en = (state == SETTLE);
   assign step      = (state == COMPARE);
   assign diff      = |(golden_in ^ cand_in);

   vector_sweep_counter #(
      .IN_W       (IN_W),
      .SETTLE_CYC (SETTLE_CYC)
   ) u_sweep (
      .clk         (clk),
      .rst         (rst),
      .clear       (accept),
      .settle_en   (settle_en),
      .step        (step),
      .stim        (stim_out),
      .last        (last),
      .settle_done (settle_done)
   );

   // busy/done are registered alongside the state so they always decode it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         mismatch_cnt <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state        <= SETTLE;
                  busy         <= 1'b1;
                  done         <= 1'b0;
                  mismatch_cnt <= '0;
               end
            end
            SETTLE: begin
               if (settle_done) begin
                  state <= COMPARE;
               end
            end
            COMPARE: begin
               if (diff) begin
                  mismatch_cnt <= mismatch_cnt + MC_W'(1);
               end
               if (last) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state <= SETTLE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   assign pass = done && (mismatch_cnt == '0);

`ifdef FIRST_FAIL_CAPTURE_EN
   // Only the first failing vector of a sweep is kept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         first_fail_vec   <= '0;
         first_fail_valid <= 1'b0;
      end else if (accept) begin
         first_fail_vec   <= '0;
         first_fail_valid <= 1'b0;
      end else if (step && diff && !first_fail_valid) begin
         first_fail_vec   <= stim_out;
         first_fail_valid <= 1'b1;
      end
   end
`else
   assign first_fail_vec   = '0;
   assign first_fail_valid = 1'b0;
`endif

endmodule

// File: tb/tb_exhaustive_equiv_checker.sv
// Scoreboard bench for exhaustive_equiv_checker: a 3-bit mux sweep and a
// 4-bit/2-output sweep with longer settle, checked against queued results.
module tb_exhaustive_equiv_checker;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

`ifdef FIRST_FAIL_CAPTURE_EN
   localparam bit CAP = 1'b1;
`else
   localparam bit CAP = 1'b0;
`endif

   // DUT A: IN_W=3, OUT_W=1, SETTLE_CYC=1, stim = {I0, I1, sel}
   logic       start_a;
   logic [2:0] stim_a;
   logic       gold_a, cand_a;
   logic       busy_a, done_a, pass_a;
   logic [3:0] mc_a;
   logic [2:0] ffv_a;
   logic       ffok_a;
   int         mode;

   always_comb begin
      gold_a = stim_a[0] ? stim_a[1] : stim_a[2];
      cand_a = gold_a;
      case (mode)
         1:       cand_a = gold_a ^ (stim_a == 3'b101);
         2:       cand_a = ~gold_a;
         default: cand_a = gold_a;
      endcase
   end

   exhaustive_equiv_checker #(.IN_W(3), .OUT_W(1), .SETTLE_CYC(1)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .stim_out(stim_a),
      .golden_in(gold_a), .cand_in(cand_a), .busy(busy_a), .done(done_a),
      .pass(pass_a), .mismatch_cnt(mc_a), .first_fail_vec(ffv_a),
      .first_fail_valid(ffok_a)
   );

   // DUT B: IN_W=4, OUT_W=2, SETTLE_CYC=3, identical designs
   logic       start_b;
   logic [3:0] stim_b;
   logic [1:0] gold_b, cand_b;
   logic       busy_b, done_b, pass_b;
   logic [4:0] mc_b;
   logic [3:0] ffv_b;
   logic       ffok_b;

   assign gold_b = {stim_b[3] ^ stim_b[0], stim_b[1] & stim_b[2]};
   assign cand_b = {stim_b[0] ^ stim_b[3], stim_b[2] & stim_b[1]};

   exhaustive_equiv_checker #(.IN_W(4), .OUT_W(2), .SETTLE_CYC(3)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .stim_out(stim_b),
      .golden_in(gold_b), .cand_in(cand_b), .busy(busy_b), .done(done_b),
      .pass(pass_b), .mismatch_cnt(mc_b), .first_fail_vec(ffv_b),
      .first_fail_valid(ffok_b)
   );

   typedef struct {
      string      name;
      logic [4:0] mc;
      logic       pass;
      logic [3:0] ffv;
      logic       ffok;
      int         lat;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   int   t_start_a = 0;
   int   t_start_b = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitors: pop the expected result whenever a done edge appears.
   bit done_q_a = 1'b0;
   bit done_q_b = 1'b0;

   always @(negedge clk) begin
      if (rst === 1'b0) begin
         chk("busy_done_excl_a", {31'd0, busy_a & done_a}, 32'd0);
         if (done_a && !done_q_a) begin
            if (q_a.size() == 0) begin
               chk("unexpected_done_a", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = q_a.pop_front();
               chk({e.name, "_mismatch_cnt"}, {28'd0, mc_a}, {27'd0, e.mc});
               chk({e.name, "_pass"}, {31'd0, pass_a}, {31'd0, e.pass});
               chk({e.name, "_first_fail_vec"}, {29'd0, ffv_a}, {28'd0, e.ffv});
               chk({e.name, "_first_fail_valid"}, {31'd0, ffok_a}, {31'd0, e.ffok});
               chk({e.name, "_latency"}, cyc - t_start_a, e.lat);
               chk({e.name, "_stim_back_to_0"}, {29'd0, stim_a}, 32'd0);
               chk({e.name, "_busy_low"}, {31'd0, busy_a}, 32'd0);
            end
         end
         if (done_b && !done_q_b) begin
            if (q_b.size() == 0) begin
               chk("unexpected_done_b", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = q_b.pop_front();
               chk({e.name, "_mismatch_cnt"}, {27'd0, mc_b}, {27'd0, e.mc});
               chk({e.name, "_pass"}, {31'd0, pass_b}, {31'd0, e.pass});
               chk({e.name, "_latency"}, cyc - t_start_b, e.lat);
            end
         end
      end
      done_q_a = (done_a === 1'b1);
      done_q_b = (done_b === 1'b1);
   end

   task automatic wait_done_a(input string name);
      int n;
      n = 0;
      while (done_a !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (done_a !== 1'b1) chk({name, "_timeout"}, 32'd1, 32'd0);
      @(negedge clk);
   endtask

   task automatic sweep_a(input string name, input int m, input logic [4:0] mc,
                          input logic ps, input logic [3:0] ffv, input logic ffok,
                          input int hold);
      exp_t e;
      e.name = name; e.mc = mc; e.pass = ps; e.ffv = ffv; e.ffok = ffok; e.lat = 16;
      @(negedge clk);
      mode = m;
      q_a.push_back(e);
      start_a = 1'b1;
      @(posedge clk);
      #1 t_start_a = cyc;
      repeat (hold) @(posedge clk);
      #1 start_a = 1'b0;
      wait_done_a(name);
   endtask

   initial begin
      int n;
      exp_t eb;
      rst = 1'b0; start_a = 1'b0; start_b = 1'b0; mode = 0;
      #1 rst = 1'b1;
      #2;
      chk("reset_stim", {29'd0, stim_a}, 32'd0);
      chk("reset_busy", {31'd0, busy_a}, 32'd0);
      chk("reset_done", {31'd0, done_a}, 32'd0);
      chk("reset_pass", {31'd0, pass_a}, 32'd0);
      chk("reset_mc", {28'd0, mc_a}, 32'd0);
      chk("reset_ffv", {29'd0, ffv_a}, 32'd0);
      chk("reset_ffok", {31'd0, ffok_a}, 32'd0);
      @(negedge clk);
      #2 rst = 1'b0;

      sweep_a("identical", 0, 5'd0, 1'b1, 4'd0, 1'b0, 0);
      sweep_a("one_diff", 1, 5'd1, 1'b0, CAP ? 4'b0101 : 4'd0, CAP, 0);
      sweep_a("inverted", 2, 5'd8, 1'b0, 4'd0, CAP, 0);
      repeat (3) @(negedge clk);
      chk("hold_done", {31'd0, done_a}, 32'd1);
      chk("hold_mc", {28'd0, mc_a}, 32'd8);
      chk("hold_busy", {31'd0, busy_a}, 32'd0);
      chk("hold_stim", {29'd0, stim_a}, 32'd0);

      sweep_a("start_held", 0, 5'd0, 1'b1, 4'd0, 1'b0, 14);

      // Abandon a sweep with an asynchronous reset while stim is 3'b100.
      @(negedge clk);
      mode = 2;
      start_a = 1'b1;
      @(posedge clk);
      #1 start_a = 1'b0;
      n = 0;
      while (stim_a !== 3'b100 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("reach_vec4", {29'd0, stim_a}, 32'd4);
      #2 rst = 1'b1;
      #1;
      chk("midrst_stim", {29'd0, stim_a}, 32'd0);
      chk("midrst_busy", {31'd0, busy_a}, 32'd0);
      chk("midrst_done", {31'd0, done_a}, 32'd0);
      chk("midrst_pass", {31'd0, pass_a}, 32'd0);
      chk("midrst_mc", {28'd0, mc_a}, 32'd0);
      chk("midrst_ffv", {29'd0, ffv_a}, 32'd0);
      chk("midrst_ffok", {31'd0, ffok_a}, 32'd0);
      #1 rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("post_rst_idle_busy", {31'd0, busy_a}, 32'd0);
      chk("post_rst_idle_done", {31'd0, done_a}, 32'd0);
      chk("post_rst_idle_stim", {29'd0, stim_a}, 32'd0);
      sweep_a("after_reset", 0, 5'd0, 1'b1, 4'd0, 1'b0, 0);

      // Wider configuration: (3+1) * 16 = 64 edges.
      @(negedge clk);
      eb.name = "wide"; eb.mc = 5'd0; eb.pass = 1'b1; eb.ffv = 4'd0; eb.ffok = 1'b0; eb.lat = 64;
      q_b.push_back(eb);
      start_b = 1'b1;
      @(posedge clk);
      #1 t_start_b = cyc;
      start_b = 1'b0;
      n = 0;
      while (done_b !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (done_b !== 1'b1) chk("wide_timeout", 32'd1, 32'd0);
      @(negedge clk);
      chk("wide_ffok", {31'd0, ffok_b}, 32'd0);

      chk("queue_a_drained", q_a.size(), 32'd0);
      chk("queue_b_drained", q_b.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
